character_btn_conditioner: RTL and testbench

Input stage directly upstream of the character physics/FSM block. It takes the three raw board buttons (left, right, jump) and produces the signals the character block consumes:
- clean, synchronised, debounced levels;
- one-cycle press/release pulses;
- a saturating jump-hold counter.

It also resolves left/right conflicts and supports gating movement while the character is airborne.

---
 rtl/character_btn_conditioner_pkg.sv | 16 +
 rtl/character_btn_conditioner_btn_debounce.sv | 84 ++++++++
 rtl/character_btn_conditioner.sv | 120 ++++++++++++
 tb/tb_character_btn_conditioner.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/character_btn_conditioner_pkg.sv
// Shared constants and debounce state encoding for the character button input stage.
package character_btn_conditioner_pkg;

  localparam int unsigned DebounceCyclesSim   = 4;
  localparam int unsigned DebounceCyclesBoard = 250000;
  localparam int unsigned HoldWidthDefault    = 8;
  localparam int unsigned HoldMaxDefault      = 255;

  typedef enum logic [1:0] {
    StStableLo = 2'd0,
    StPendHi   = 2'd1,
    StStableHi = 2'd2,
    StPendLo   = 2'd3
  } db_state_e;

endpackage

// File: rtl/character_btn_conditioner_btn_debounce.sv
// Two-flop synchroniser followed by a four-state debounce FSM; clean_o changes only after
// DEBOUNCE_CYCLES consecutive synchronised samples at the new level.
module character_btn_conditioner_btn_debounce
  import character_btn_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesSim,
  parameter int unsigned DB_CNT_WIDTH    = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic clean_o
);

  localparam logic [DB_CNT_WIDTH-1:0] CntLast = DB_CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_CNT_WIDTH-1:0] CntOne  = DB_CNT_WIDTH'(1);

  logic                    sync1_q, sync1_d, sync2_q, sync2_d;
  db_state_e               state_q, state_d;
  logic [DB_CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= StStableLo;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    sync1_d = raw_i;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StStableLo: begin
        if (sync2_q) begin
          state_d = StPendHi;
          cnt_d   = CntOne;
        end
      end
      StPendHi: begin
        if (!sync2_q) begin
          state_d = StStableLo;
          cnt_d   = '0;
        end else if (cnt_q >= CntLast) begin
          state_d = StStableHi;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StStableHi: begin
        if (!sync2_q) begin
          state_d = StPendLo;
          cnt_d   = CntOne;
        end
      end
      StPendLo: begin
        if (sync2_q) begin
          state_d = StStableHi;
          cnt_d   = '0;
        end else if (cnt_q >= CntLast) begin
          state_d = StStableLo;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
    endcase
  end

  // A pending fall still reports high until the new level is confirmed.
  always_comb begin
    clean_o = (state_q == StStableHi) || (state_q == StPendLo);
  end

endmodule

// File: rtl/character_btn_conditioner.sv
// Button conditioning for the character block: debounced levels, left/right conflict
// resolution with movement gating, edge pulses and a saturating jump-hold counter.
module character_btn_conditioner
  import character_btn_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesSim,
  parameter int unsigned DB_CNT_WIDTH    = $clog2(DEBOUNCE_CYCLES + 1),
  parameter int unsigned HOLD_WIDTH      = HoldWidthDefault,
  parameter int unsigned HOLD_MAX        = HoldMaxDefault
) (
  input  logic                  character_clk,
  input  logic                  sys_rst_n,
  input  logic                  raw_left,
  input  logic                  raw_right,
  input  logic                  raw_jump,
  input  logic                  move_enable,
  output logic                  left_btn,
  output logic                  right_btn,
  output logic                  jump_btn,
  output logic                  left_press,
  output logic                  right_press,
  output logic                  jump_press,
  output logic                  jump_release,
  output logic [HOLD_WIDTH-1:0] jump_hold_cnt,
  output logic [HOLD_WIDTH-1:0] jump_hold_last
);

  localparam logic [HOLD_WIDTH-1:0] HoldMaxVal = HOLD_WIDTH'(HOLD_MAX);
  localparam logic [HOLD_WIDTH-1:0] HoldOne    = HOLD_WIDTH'(1);

  logic clean_l, clean_r, clean_j;

  logic left_btn_q, left_btn_d, right_btn_q, right_btn_d, jump_btn_q, jump_btn_d;
  logic left_prev_q, left_prev_d, right_prev_q, right_prev_d, jump_prev_q, jump_prev_d;
  logic [HOLD_WIDTH-1:0] hold_cnt_q, hold_cnt_d, hold_last_q, hold_last_d;

  character_btn_conditioner_btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DB_CNT_WIDTH   (DB_CNT_WIDTH)
  ) u_db_left (
    .clk_i  (character_clk),
    .rst_ni (sys_rst_n),
    .raw_i  (raw_left),
    .clean_o(clean_l)
  );

  character_btn_conditioner_btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DB_CNT_WIDTH   (DB_CNT_WIDTH)
  ) u_db_right (
    .clk_i  (character_clk),
    .rst_ni (sys_rst_n),
    .raw_i  (raw_right),
    .clean_o(clean_r)
  );

  character_btn_conditioner_btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DB_CNT_WIDTH   (DB_CNT_WIDTH)
  ) u_db_jump (
    .clk_i  (character_clk),
    .rst_ni (sys_rst_n),
    .raw_i  (raw_jump),
    .clean_o(clean_j)
  );

  always_ff @(posedge character_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      left_btn_q   <= 1'b0;
      right_btn_q  <= 1'b0;
      jump_btn_q   <= 1'b0;
      left_prev_q  <= 1'b0;
      right_prev_q <= 1'b0;
      jump_prev_q  <= 1'b0;
      hold_cnt_q   <= '0;
      hold_last_q  <= '0;
    end else begin
      left_btn_q   <= left_btn_d;
      right_btn_q  <= right_btn_d;
      jump_btn_q   <= jump_btn_d;
      left_prev_q  <= left_prev_d;
      right_prev_q <= right_prev_d;
      jump_prev_q  <= jump_prev_d;
      hold_cnt_q   <= hold_cnt_d;
      hold_last_q  <= hold_last_d;
    end
  end

  always_comb begin
    // Both directions held cancel out; releasing one re-asserts the other.
    left_btn_d   = clean_l & ~clean_r & move_enable;
    right_btn_d  = clean_r & ~clean_l & move_enable;
    jump_btn_d   = clean_j;
    left_prev_d  = left_btn_q;
    right_prev_d = right_btn_q;
    jump_prev_d  = jump_btn_q;
    hold_cnt_d   = hold_cnt_q;
    hold_last_d  = hold_last_q;
    // Counting from clean_j makes the counter read 1 on the same edge jump_btn rises.
    if (jump_btn_d == 1'b0 && jump_release) begin
      hold_last_d = hold_cnt_q;
      hold_cnt_d  = '0;
    end else if (clean_j && (hold_cnt_q < HoldMaxVal)) begin
      hold_cnt_d = hold_cnt_q + HoldOne;
    end
  end

  always_comb begin
    left_btn       = left_btn_q;
    right_btn      = right_btn_q;
    jump_btn       = jump_btn_q;
    left_press     = left_btn_q & ~left_prev_q;
    right_press    = right_btn_q & ~right_prev_q;
    jump_press     = jump_btn_q & ~jump_prev_q;
    jump_release   = ~jump_btn_q & jump_prev_q;
    jump_hold_cnt  = hold_cnt_q;
    jump_hold_last = hold_last_q;
  end

endmodule

// File: tb/tb_character_btn_conditioner.sv
// Directed bench for character_btn_conditioner with DEBOUNCE_CYCLES=4 (raw edge to output: 7 edges).
module tb_character_btn_conditioner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       raw_left = 1'b0, raw_right = 1'b0, raw_jump = 1'b0, move_enable = 1'b1;
  logic       left_btn, right_btn, jump_btn;
  logic       left_press, right_press, jump_press, jump_release;
  logic [7:0] jump_hold_cnt, jump_hold_last;
  logic [6:0] flags;

  int n_vec = 0;
  int n_err = 0;

  // {left_btn, right_btn, jump_btn, left_press, right_press, jump_press, jump_release}
  assign flags = {left_btn, right_btn, jump_btn, left_press, right_press, jump_press, jump_release};

  always #5 clk = ~clk;

  character_btn_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .DB_CNT_WIDTH   (3),
    .HOLD_WIDTH     (8),
    .HOLD_MAX       (255)
  ) dut (
    .character_clk (clk),
    .sys_rst_n     (rst_n),
    .raw_left      (raw_left),
    .raw_right     (raw_right),
    .raw_jump      (raw_jump),
    .move_enable   (move_enable),
    .left_btn      (left_btn),
    .right_btn     (right_btn),
    .jump_btn      (jump_btn),
    .left_press    (left_press),
    .right_press   (right_press),
    .jump_press    (jump_press),
    .jump_release  (jump_release),
    .jump_hold_cnt (jump_hold_cnt),
    .jump_hold_last(jump_hold_last)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    raw_left    = 1'b0;
    raw_right   = 1'b0;
    raw_jump    = 1'b0;
    move_enable = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (flags !== 7'b0 || jump_hold_cnt !== 8'd0 || jump_hold_last !== 8'd0) begin
      n_err++;
      $display("FAIL reset_state flags=%b cnt=%0d last=%0d, expected all zero",
               flags, jump_hold_cnt, jump_hold_last);
    end
    repeat (10) step();
    n_vec++;
    if (flags !== 7'b0 || jump_hold_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL idle_quiet flags=%b cnt=%0d, expected all zero", flags, jump_hold_cnt);
    end
  endtask

  task automatic test_left_press();
    logic [6:0] exp;
    do_reset();
    raw_left = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      exp    = 7'b0;
      exp[6] = (k >= 7);
      exp[3] = (k == 7);
      n_vec++;
      if (flags !== exp) begin
        n_err++;
        $display("FAIL left_press edge=%0d flags=%b expected %b", k, flags, exp);
      end
    end
  endtask

  task automatic test_bounce();
    logic [6:0] exp;
    do_reset();
    for (int k = 1; k <= 18; k++) begin
      raw_jump = (k <= 2) || (k == 5) || (k == 6) || (k >= 9);
      step();
      exp    = 7'b0;
      exp[4] = (k >= 15);
      exp[1] = (k == 15);
      n_vec++;
      if (flags !== exp) begin
        n_err++;
        $display("FAIL jump_bounce edge=%0d flags=%b expected %b", k, flags, exp);
      end
    end
  endtask

  task automatic test_hold(input int rel);
    logic [6:0] exp;
    logic [7:0] exp_cnt, exp_last, sat_rel;
    do_reset();
    sat_rel = (rel > 255) ? 8'd255 : 8'(rel);
    for (int k = 1; k <= rel + 9; k++) begin
      raw_jump = (k <= rel);
      step();
      exp    = 7'b0;
      exp[4] = (k >= 7) && (k <= rel + 6);
      exp[1] = (k == 7);
      exp[0] = (k == rel + 7);
      if (k < 7)              exp_cnt = 8'd0;
      else if (k <= rel + 6)  exp_cnt = (k - 6 > 255) ? 8'd255 : 8'(k - 6);
      else if (k == rel + 7)  exp_cnt = sat_rel;
      else                    exp_cnt = 8'd0;
      exp_last = (k > rel + 7) ? sat_rel : 8'd0;
      n_vec++;
      if (flags !== exp || jump_hold_cnt !== exp_cnt || jump_hold_last !== exp_last) begin
        n_err++;
        $display("FAIL jump_hold rel=%0d edge=%0d flags=%b cnt=%0d last=%0d expected %b %0d %0d",
                 rel, k, flags, jump_hold_cnt, jump_hold_last, exp, exp_cnt, exp_last);
      end
    end
  endtask

  task automatic test_conflict();
    logic [6:0] exp;
    do_reset();
    for (int k = 1; k <= 30; k++) begin
      raw_left  = (k <= 20);
      raw_right = (k >= 11);
      step();
      exp    = 7'b0;
      exp[6] = (k >= 7) && (k <= 16);
      exp[5] = (k >= 27);
      exp[3] = (k == 7);
      exp[2] = (k == 27);
      n_vec++;
      if (flags !== exp) begin
        n_err++;
        $display("FAIL lr_conflict edge=%0d flags=%b expected %b", k, flags, exp);
      end
    end
  endtask

  task automatic test_move_enable();
    logic [6:0] exp;
    do_reset();
    for (int k = 1; k <= 24; k++) begin
      raw_left    = 1'b1;
      raw_jump    = (k >= 11);
      move_enable = !((k >= 11) && (k <= 20));
      step();
      exp    = 7'b0;
      exp[6] = ((k >= 7) && (k <= 10)) || (k >= 21);
      exp[3] = (k == 7) || (k == 21);
      exp[4] = (k >= 17);
      exp[1] = (k == 17);
      n_vec++;
      if (flags !== exp) begin
        n_err++;
        $display("FAIL move_enable edge=%0d flags=%b expected %b", k, flags, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] exp;
    logic [7:0] exp_cnt;
    do_reset();
    raw_jump = 1'b1;
    repeat (56) step();
    n_vec++;
    if (jump_btn !== 1'b1 || jump_hold_cnt !== 8'd50) begin
      n_err++;
      $display("FAIL pre_reset_hold jump_btn=%b cnt=%0d expected 1 50", jump_btn, jump_hold_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (flags !== 7'b0 || jump_hold_cnt !== 8'd0 || jump_hold_last !== 8'd0) begin
      n_err++;
      $display("FAIL async_reset flags=%b cnt=%0d last=%0d expected all zero",
               flags, jump_hold_cnt, jump_hold_last);
    end
    repeat (2) step();
    n_vec++;
    if (flags !== 7'b0) begin
      n_err++;
      $display("FAIL in_reset flags=%b expected 0000000", flags);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      exp     = 7'b0;
      exp[4]  = (k >= 7);
      exp[1]  = (k == 7);
      exp_cnt = (k >= 7) ? 8'(k - 6) : 8'd0;
      n_vec++;
      if (flags !== exp || jump_hold_cnt !== exp_cnt || jump_hold_last !== 8'd0) begin
        n_err++;
        $display("FAIL post_reset edge=%0d flags=%b cnt=%0d last=%0d expected %b %0d 0",
                 k, flags, jump_hold_cnt, jump_hold_last, exp, exp_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_left_press();
    test_bounce();
    test_hold(20);
    test_hold(300);
    test_conflict();
    test_move_enable();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
